game_flow_ctrl: RTL and testbench

Parametrised top-level game flow controller: it tracks Start, Roam, Battle and End. It replaces the fixed 8-choice / 3-member team picker with a configurable grid, team size and battle count. It adds key press-edge detection, duplicate-pick rejection, undo of the last pick, and a win/loss verdict. It drives the state flags and team data used by the sprite, roaming and battle blocks.

---
 rtl/game_flow_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl
//  Description : Game flow controller that tracks Start / Roam / Battle / End.
//                In Start the player moves a cursor over a GRID_COLS x
//                GRID_ROWS selection grid (W/A/S/D, wrapping) and builds a
//                team of TEAM_SIZE distinct members (ENTER picks, BACKSPACE
//                undoes the last pick). Once the team is full, any other key
//                press enters Roam. Roam counts rooms and starts battles; a
//                battle either returns to Roam (win), ends the game as a
//                victory (MAX_BATTLES wins) or as a loss. In End, W restarts.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk           in   system clock
//    Reset         in   synchronous active-high reset
//    keycode       in   8-bit USB keycode, 0 = no key
//    start_battle  in   roam block requests a battle (pulse)
//    end_battle    in   battle block finished (pulse)
//    result        in   qualifies end_battle: 1 = player won
//    new_room      in   player entered a new room (pulse)
//    is_start/is_roam/is_battle/is_end  out  one-hot state flags
//    cur_choice    out  cursor id, row*GRID_COLS+col
//    my_team       out  picked ids, slot k at [k*ID_W +: ID_W]
//    num_chosen    out  members picked so far
//    team_full     out  num_chosen == TEAM_SIZE
//    rooms         out  rooms entered, saturating at MAX_BATTLES
//    wins          out  battles won this game
//    victory       out  valid in End: 1 = all battles won
// ============================================================================
module game_flow_ctrl #(
    parameter int GRID_COLS   = 4,
    parameter int GRID_ROWS   = 2,
    parameter int TEAM_SIZE   = 3,
    parameter int MAX_BATTLES = 4,
    parameter int ID_W        = $clog2(GRID_COLS*GRID_ROWS),
    parameter int CNT_W       = $clog2(MAX_BATTLES+1)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [7:0]                    keycode,
    input  logic                          start_battle,
    input  logic                          end_battle,
    input  logic                          result,
    input  logic                          new_room,
    output logic                          is_start,
    output logic                          is_roam,
    output logic                          is_battle,
    output logic                          is_end,
    output logic [ID_W-1:0]               cur_choice,
    output logic [TEAM_SIZE*ID_W-1:0]     my_team,
    output logic [$clog2(TEAM_SIZE+1)-1:0] num_chosen,
    output logic                          team_full,
    output logic [CNT_W-1:0]              rooms,
    output logic [CNT_W-1:0]              wins,
    output logic                          victory
);

    localparam int NUM_W = $clog2(TEAM_SIZE+1);

    localparam logic [7:0] C_KEY_W     = 8'h1A;
    localparam logic [7:0] C_KEY_A     = 8'h04;
    localparam logic [7:0] C_KEY_S     = 8'h16;
    localparam logic [7:0] C_KEY_D     = 8'h07;
    localparam logic [7:0] C_KEY_ENTER = 8'h28;
    localparam logic [7:0] C_KEY_BKSP  = 8'h2A;

    localparam logic [NUM_W-1:0] C_TEAM_SIZE = NUM_W'(TEAM_SIZE);
    localparam logic [CNT_W-1:0] C_MAX_BATT  = CNT_W'(MAX_BATTLES);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_ROAM   = 2'd1,
        S_BATTLE = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                    r_state,      w_state_nxt;
    logic [ID_W-1:0]           r_cur_choice, w_cur_nxt;
    logic [TEAM_SIZE*ID_W-1:0] r_my_team,    w_team_nxt;
    logic [NUM_W-1:0]          r_num_chosen, w_num_nxt;
    logic [CNT_W-1:0]          r_rooms,      w_rooms_nxt;
    logic [CNT_W-1:0]          r_wins,       w_wins_nxt;
    logic                      r_victory,    w_victory_nxt;
    logic                      r_team_full;
    logic [7:0]                r_prev_key;
    logic                      r_is_start, r_is_roam, r_is_battle, r_is_end;

    logic                      w_press;
    logic                      w_dup;

    // Cursor step with wrap inside the current row (A/D) or column (W/S).
    function automatic logic [ID_W-1:0] f_move(input logic [ID_W-1:0] cur,
                                               input logic [7:0]      key);
        int col;
        int row;
        col = int'(cur) % GRID_COLS;
        row = int'(cur) / GRID_COLS;
        case (key)
            C_KEY_A: col = (col == 0) ? GRID_COLS - 1 : col - 1;
            C_KEY_D: col = (col == GRID_COLS - 1) ? 0 : col + 1;
            C_KEY_W: row = (row == 0) ? GRID_ROWS - 1 : row - 1;
            C_KEY_S: row = (row == GRID_ROWS - 1) ? 0 : row + 1;
            default: ;
        endcase
        return ID_W'(row * GRID_COLS + col);
    endfunction

    // A press is a non-zero keycode that differs from last cycle's keycode,
    // so a held key fires once and a direct key-to-key change fires again.
    assign w_press = (keycode != 8'h00) && (keycode != r_prev_key);

    // Only the live slots (below num_chosen) count; undone slots keep stale
    // ids that must not block a re-pick.
    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < TEAM_SIZE; k++) begin
            if ((k < int'(r_num_chosen)) &&
                (r_my_team[k*ID_W +: ID_W] == r_cur_choice)) begin
                w_dup = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur_choice;
        w_team_nxt    = r_my_team;
        w_num_nxt     = r_num_chosen;
        w_rooms_nxt   = r_rooms;
        w_wins_nxt    = r_wins;
        w_victory_nxt = r_victory;

        case (r_state)
            S_START: begin
                if (w_press) begin
                    if (keycode == C_KEY_ENTER) begin
                        if (!r_team_full && !w_dup) begin
                            w_team_nxt[int'(r_num_chosen)*ID_W +: ID_W] = r_cur_choice;
                            w_num_nxt = r_num_chosen + NUM_W'(1);
                        end
                    end else if (keycode == C_KEY_BKSP) begin
                        if (r_num_chosen != '0) begin
                            w_num_nxt = r_num_chosen - NUM_W'(1);
                        end
                    end else if (r_team_full) begin
                        // The leaving key is consumed; the cursor stays put.
                        w_state_nxt = S_ROAM;
                    end else begin
                        w_cur_nxt = f_move(r_cur_choice, keycode);
                    end
                end
            end

            S_ROAM: begin
                if (new_room && (r_rooms != C_MAX_BATT)) begin
                    w_rooms_nxt = r_rooms + CNT_W'(1);
                end
                if (start_battle) begin
                    w_state_nxt = S_BATTLE;
                end
            end

            S_BATTLE: begin
                if (end_battle) begin
                    if (result) begin
                        w_wins_nxt = r_wins + CNT_W'(1);
                        if (w_wins_nxt == C_MAX_BATT) begin
                            w_state_nxt   = S_END;
                            w_victory_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_ROAM;
                        end
                    end else begin
                        w_state_nxt   = S_END;
                        w_victory_nxt = 1'b0;
                    end
                end
            end

            S_END: begin
                // Restart keeps my_team so the previous team stays visible.
                if (w_press && (keycode == C_KEY_W)) begin
                    w_state_nxt   = S_START;
                    w_num_nxt     = '0;
                    w_wins_nxt    = '0;
                    w_rooms_nxt   = '0;
                    w_victory_nxt = 1'b0;
                    w_cur_nxt     = '0;
                end
            end

            default: w_state_nxt = S_START;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_START;
            r_cur_choice <= '0;
            r_my_team    <= '0;
            r_num_chosen <= '0;
            r_team_full  <= 1'b0;
            r_rooms      <= '0;
            r_wins       <= '0;
            r_victory    <= 1'b0;
            r_prev_key   <= 8'h00;
            r_is_start   <= 1'b1;
            r_is_roam    <= 1'b0;
            r_is_battle  <= 1'b0;
            r_is_end     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_choice <= w_cur_nxt;
            r_my_team    <= w_team_nxt;
            r_num_chosen <= w_num_nxt;
            r_team_full  <= (w_num_nxt == C_TEAM_SIZE);
            r_rooms      <= w_rooms_nxt;
            r_wins       <= w_wins_nxt;
            r_victory    <= w_victory_nxt;
            r_prev_key   <= keycode;
            r_is_start   <= (w_state_nxt == S_START);
            r_is_roam    <= (w_state_nxt == S_ROAM);
            r_is_battle  <= (w_state_nxt == S_BATTLE);
            r_is_end     <= (w_state_nxt == S_END);
        end
    end

    assign is_start   = r_is_start;
    assign is_roam    = r_is_roam;
    assign is_battle  = r_is_battle;
    assign is_end     = r_is_end;
    assign cur_choice = r_cur_choice;
    assign my_team    = r_my_team;
    assign num_chosen = r_num_chosen;
    assign team_full  = r_team_full;
    assign rooms      = r_rooms;
    assign wins       = r_wins;
    assign victory    = r_victory;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_ctrl
//  Description : Scoreboard bench for game_flow_ctrl. A driver applies one
//                input vector per cycle, steps a game-rules reference model
//                and queues the expected outputs; a monitor pops the queue
//                after every clock edge and compares all outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam int GC    = 4;
    localparam int GR    = 2;
    localparam int TS    = 3;
    localparam int MB    = 4;
    localparam int ID_W  = $clog2(GC*GR);
    localparam int CNT_W = $clog2(MB+1);
    localparam int NUM_W = $clog2(TS+1);

    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07;
    localparam logic [7:0] K_ENT = 8'h28, K_BS = 8'h2A;

    logic                    Clk = 1'b0;
    logic                    Reset = 1'b1;
    logic [7:0]              keycode = 8'h00;
    logic                    start_battle = 1'b0, end_battle = 1'b0;
    logic                    result = 1'b0, new_room = 1'b0;
    logic                    is_start, is_roam, is_battle, is_end;
    logic [ID_W-1:0]         cur_choice;
    logic [TS*ID_W-1:0]      my_team;
    logic [NUM_W-1:0]        num_chosen;
    logic                    team_full;
    logic [CNT_W-1:0]        rooms, wins;
    logic                    victory;

    game_flow_ctrl #(
        .GRID_COLS(GC), .GRID_ROWS(GR), .TEAM_SIZE(TS), .MAX_BATTLES(MB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode),
        .start_battle(start_battle), .end_battle(end_battle),
        .result(result), .new_room(new_room),
        .is_start(is_start), .is_roam(is_roam), .is_battle(is_battle),
        .is_end(is_end), .cur_choice(cur_choice), .my_team(my_team),
        .num_chosen(num_chosen), .team_full(team_full), .rooms(rooms),
        .wins(wins), .victory(victory)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]         flags;   // {start, roam, battle, end}
        int                 cur;
        logic [TS*ID_W-1:0] team;
        int                 count;
        int                 full;
        int                 rooms;
        int                 wins;
        int                 vic;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model (game rules) ----------------
    int         m_mode;   // 0 Start, 1 Roam, 2 Battle, 3 End
    int         m_row, m_col, m_count, m_rooms, m_wins, m_vic;
    int         m_slots[TS];
    logic [7:0] m_prev;

    function automatic bit m_picked(int id);
        for (int k = 0; k < m_count; k++) if (m_slots[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(bit rst, logic [7:0] key, bit sb, bit eb, bit res, bit nr);
        bit   press;
        exp_t e;
        if (rst) begin
            m_mode = 0; m_row = 0; m_col = 0; m_count = 0;
            m_rooms = 0; m_wins = 0; m_vic = 0; m_prev = 8'h00;
            for (int k = 0; k < TS; k++) m_slots[k] = 0;
        end else begin
            press = (key != 8'h00) && (key != m_prev);
            case (m_mode)
                0: if (press) begin
                    if (key == K_ENT) begin
                        if (m_count < TS && !m_picked(m_row*GC + m_col)) begin
                            m_slots[m_count] = m_row*GC + m_col;
                            m_count++;
                        end
                    end else if (key == K_BS) begin
                        if (m_count > 0) m_count--;
                    end else if (m_count == TS) begin
                        m_mode = 1;
                    end else if (key == K_A) m_col = (m_col + GC - 1) % GC;
                    else if (key == K_D) m_col = (m_col + 1) % GC;
                    else if (key == K_W) m_row = (m_row + GR - 1) % GR;
                    else if (key == K_S) m_row = (m_row + 1) % GR;
                end
                1: begin
                    if (nr && m_rooms < MB) m_rooms++;
                    if (sb) m_mode = 2;
                end
                2: if (eb) begin
                    if (res) begin
                        m_wins++;
                        if (m_wins == MB) begin m_mode = 3; m_vic = 1; end
                        else m_mode = 1;
                    end else begin
                        m_mode = 3; m_vic = 0;
                    end
                end
                default: if (press && key == K_W) begin
                    m_mode = 0; m_count = 0; m_wins = 0; m_rooms = 0;
                    m_vic = 0; m_row = 0; m_col = 0;
                end
            endcase
            m_prev = key;
        end
        e.flags = 4'b1000 >> m_mode;
        e.cur   = m_row*GC + m_col;
        e.team  = '0;
        for (int k = 0; k < TS; k++) e.team[k*ID_W +: ID_W] = ID_W'(m_slots[k]);
        e.count = m_count;
        e.full  = (m_count == TS) ? 1 : 0;
        e.rooms = m_rooms;
        e.wins  = m_wins;
        e.vic   = m_vic;
        expq.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic cyc(bit rst, logic [7:0] key, bit sb, bit eb, bit res, bit nr);
        Reset = rst; keycode = key; start_battle = sb;
        end_battle = eb; result = res; new_room = nr;
        model_step(rst, key, sb, eb, res, nr);
        @(negedge Clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic press(logic [7:0] k);
        cyc(0, k, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic hold(logic [7:0] k, int n);
        for (int i = 0; i < n; i++) cyc(0, k, 0, 0, 0, 0);
    endtask

    task automatic battle(bit res);
        cyc(0, 8'h00, 1, 0, 0, 1);
        idle(2);
        cyc(0, 8'h00, 0, 1, res, 0);
        idle(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string nm, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("state_flags", {is_start, is_roam, is_battle, is_end}, e.flags);
                chk("cur_choice", cur_choice, e.cur);
                chk("my_team", my_team, e.team);
                chk("num_chosen", num_chosen, e.count);
                chk("team_full", team_full, e.full);
                chk("rooms", rooms, e.rooms);
                chk("wins", wins, e.wins);
                chk("victory", victory, e.vic);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] keyset [10];

    initial begin
        logic [7:0] k;
        keyset = '{8'h00, 8'h00, K_W, K_A, K_S, K_D, K_ENT, K_ENT, K_BS, 8'h55};

        cyc(1, 8'h00, 0, 0, 0, 0);
        cyc(1, 8'h00, 0, 0, 0, 0);

        // Navigation: held D moves once, then wrap and row moves.
        hold(K_D, 5); idle(1);
        press(K_D); press(K_D); press(K_D);
        press(K_S); press(K_W);

        // Pick, duplicate, undo, re-pick.
        press(K_ENT); press(K_ENT);
        press(K_D); press(K_S); press(K_ENT);
        press(K_BS);
        press(K_W); press(K_D); press(K_ENT);
        press(K_D); press(K_ENT);
        press(K_ENT);              // full: ignored
        press(K_A);                // leaves Start, cursor stays

        // Full win with some room entries.
        for (int i = 0; i < MB; i++) battle(1);
        cyc(0, 8'h00, 0, 0, 0, 1);  // new_room ignored in End

        // Restart, long W hold, single move after re-press.
        hold(K_W, 10); idle(1);
        press(K_W);

        // Direct key-to-key change counts as a new press.
        cyc(0, K_D, 0, 0, 0, 0); cyc(0, K_S, 0, 0, 0, 0); idle(1);

        // Rebuild team, then lose the first battle.
        press(K_ENT); press(K_A); press(K_ENT); press(K_A); press(K_ENT);
        press(K_S);
        battle(0);
        press(K_W);

        // Simultaneous start_battle/new_room, then reset during a battle end.
        press(K_ENT); press(K_D); press(K_ENT); press(K_D); press(K_ENT);
        press(K_D);
        cyc(0, 8'h00, 1, 0, 0, 1);
        cyc(1, K_D, 0, 1, 1, 1);
        idle(2);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) k = keycode;
            else k = keyset[$urandom_range(0, 9)];
            cyc(($urandom_range(0, 299) == 0),
                k,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0));
        end
        idle(2);

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(posedge Clk);
        #2;
        if (expq.size() != 0) chk("scoreboard_drain", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
